gshare_fetch_predictor: RTL

//  Parametrised IF-stage front end for the pipelined RV32I core. Replaces the fixed PC/PC+4 adder.

---
 rtl/bp_pkg.sv | 17 +
 rtl/sat_counter2.sv | 24 ++
 rtl/gshare_fetch_predictor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Branch-prediction shared definitions: counter encodings and instruction width.
package bp_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned INST_BYTES = INST_W / 8;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [CNT_W-1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt_e;

    localparam cnt_e PHT_RESET = CNT_WNT;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter next-state function.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [CNT_W-1:0] cur,
    input  logic             inc,
    output logic [CNT_W-1:0] nxt_c
);

    // Step toward strongly-taken or strongly-not-taken, clamping at the ends.
    always_comb begin
        nxt_c = cur;
        if (inc) begin
            if (cur != CNT_ST) begin
                nxt_c = cur + CNT_W'(1);
            end
        end else begin
            if (cur != CNT_SNT) begin
                nxt_c = cur - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gshare_fetch_predictor.sv
// IF-stage PC owner with direct-mapped BTB and gshare PHT next-PC prediction.
module gshare_fetch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     BTB_IDX  = 5,
    parameter int unsigned     GHR_BITS = 6,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pc_write,
    output logic [XLEN-1:0]     current_pc,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic                upd_is_cond,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc
);

    localparam int unsigned BTB_N = 1 << BTB_IDX;
    localparam int unsigned PHT_N = 1 << GHR_BITS;
    localparam int unsigned TAG_W = XLEN - BTB_IDX - 2;

    logic [XLEN-1:0]     pc_q;
    logic [GHR_BITS-1:0] ghr_q;

    logic                btb_valid  [BTB_N];
    logic [TAG_W-1:0]    btb_tag    [BTB_N];
    logic [XLEN-1:0]     btb_target [BTB_N];
    logic                btb_cond   [BTB_N];
    logic [CNT_W-1:0]    pht        [PHT_N];

    logic [BTB_IDX-1:0]  bidx_c;
    logic [GHR_BITS-1:0] pidx_c;
    logic                hit_c;
    logic                hit_cond_c;
    logic                pred_c;
    logic [XLEN-1:0]     next_pc_c;
    logic [GHR_BITS-1:0] redirect_ghr_c;

    logic [BTB_IDX-1:0]  ubidx_c;
    logic [GHR_BITS-1:0] upidx_c;
    logic [CNT_W-1:0]    pht_nxt_c;

    logic                unused_upd_low_c;

    // Alignment bits of the update PC carry no information.
    assign unused_upd_low_c = ^upd_pc[1:0];

    // Zero-cycle lookup on the PC currently being fetched.
    always_comb begin
        bidx_c     = pc_q[BTB_IDX+1:2];
        pidx_c     = pc_q[GHR_BITS+1:2] ^ ghr_q;
        hit_c      = btb_valid[bidx_c] && (btb_tag[bidx_c] == pc_q[XLEN-1:BTB_IDX+2]);
        hit_cond_c = hit_c && btb_cond[bidx_c];
        pred_c     = hit_c && (!btb_cond[bidx_c] || pht[pidx_c][1]);
        next_pc_c  = pred_c ? btb_target[bidx_c] : pc_q + XLEN'(INST_BYTES);
    end

    // Recovered history on a redirect: the snapshot plus the resolved outcome for branches.
    always_comb begin
        redirect_ghr_c = upd_ghr;
        if (upd_is_cond) begin
            redirect_ghr_c = {upd_ghr[GHR_BITS-2:0], upd_taken};
        end
    end

    // Update-side indices into the tables.
    always_comb begin
        ubidx_c = upd_pc[BTB_IDX+1:2];
        upidx_c = upd_pc[GHR_BITS+1:2] ^ upd_ghr;
    end

    sat_counter2 u_pht_cnt (
        .cur   (pht[upidx_c]),
        .inc   (upd_taken),
        .nxt_c (pht_nxt_c)
    );

    // PC and global history: reset, then redirect, then stall, then predicted advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ghr_q <= '0;
        end else if (redirect_valid) begin
            pc_q  <= redirect_pc;
            ghr_q <= redirect_ghr_c;
        end else if (pc_write) begin
            pc_q <= next_pc_c;
            if (hit_cond_c) begin
                ghr_q <= {ghr_q[GHR_BITS-2:0], pred_c};
            end
        end
    end

    // BTB and PHT training from resolved control flow, independent of stall/redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < BTB_N; i++) begin
                btb_valid[BTB_IDX'(i)]  <= 1'b0;
                btb_tag[BTB_IDX'(i)]    <= '0;
                btb_target[BTB_IDX'(i)] <= '0;
                btb_cond[BTB_IDX'(i)]   <= 1'b0;
            end
            for (int unsigned j = 0; j < PHT_N; j++) begin
                pht[GHR_BITS'(j)] <= PHT_RESET;
            end
        end else if (upd_valid) begin
            if (upd_is_cond) begin
                pht[upidx_c] <= pht_nxt_c;
            end
            if (upd_taken) begin
                btb_valid[ubidx_c]  <= 1'b1;
                btb_tag[ubidx_c]    <= upd_pc[XLEN-1:BTB_IDX+2];
                btb_target[ubidx_c] <= upd_target;
                btb_cond[ubidx_c]   <= upd_is_cond;
            end
        end
    end

    assign current_pc = pc_q;
    assign pred_taken = pred_c;
    assign pred_ghr   = ghr_q;

endmodule
